// File: rtl/game_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : game_io_pkg                                                |
// | Brief   : Shared phase encoding and X-range defaults for game I/O.   |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package game_io_pkg;

   typedef enum logic [1:0] {
      RESET_REQ  = 2'd0,
      WAIT_START = 2'd1,
      PLAY       = 2'd2,
      OVER       = 2'd3
   } phase_e;

   localparam int c_DEBOUNCE_DEFAULT   = 250000;
   localparam int c_RESET_HOLD_DEFAULT = 4;
   localparam int c_X_W_DEFAULT        = 10;
   localparam int c_X_MIN              = 0;
   localparam int c_X_MAX              = 608;
   localparam int c_X_RESET            = 304;

endpackage
`default_nettype wire

// File: rtl/game_io_ctrl_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : key_debounce                                               |
// | Brief   : 2-flop synchroniser plus stability counter for one key.    |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic key_raw_i,
   output logic key_o
);

   localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic               sync1_q;
   logic               sync2_q;
   logic               level_q;
   logic               level_d;
   logic [c_CNT_W-1:0] cnt_q;
   logic [c_CNT_W-1:0] cnt_d;

   // Counter only advances while the synchronised input disagrees with the level.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == c_CNT_MAX) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign key_o = level_q;

endmodule
`default_nettype wire

// File: rtl/game_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : game_io_ctrl                                               |
// | Brief   : Key debounce, game-phase FSM, move gating and X clamping.  |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module game_io_ctrl
   import game_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = c_DEBOUNCE_DEFAULT,
   parameter int RESET_HOLD_FRAMES = c_RESET_HOLD_DEFAULT,
   parameter int X_W               = c_X_W_DEFAULT,
   parameter int X_MIN             = c_X_MIN,
   parameter int X_MAX             = c_X_MAX,
   parameter int X_RESET           = c_X_RESET
) (
   input  logic           clock,
   input  logic           ctrl_reset_n,
   input  logic           key_left_raw,
   input  logic           key_right_raw,
   input  logic           key_start_raw,
   input  logic           collision,
   input  logic           frame_tick,
   input  logic [31:0]    spaceship_x_in,
   output logic           move_left,
   output logic           move_right,
   output logic           game_status,
   output logic [X_W-1:0] spaceship_x_out,
   output logic [1:0]     phase
);

   localparam int c_KEY_LEFT  = 0;
   localparam int c_KEY_RIGHT = 1;
   localparam int c_KEY_START = 2;
   localparam int c_FCNT_W    = (RESET_HOLD_FRAMES > 1) ? $clog2(RESET_HOLD_FRAMES + 1) : 1;
   localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(RESET_HOLD_FRAMES - 1);

   logic [2:0]          w_raw;
   logic [2:0]          w_deb;
   logic                w_start_press;
   logic [X_W-1:0]      w_x_clamped;

   phase_e              state_q;
   logic [c_FCNT_W-1:0] fcnt_q;
   logic                start_prev_q;
   logic                game_status_q;
   logic                move_left_q;
   logic                move_right_q;
   logic [X_W-1:0]      x_q;

   assign w_raw = {key_start_raw, key_right_raw, key_left_raw};

   for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i    (clock),
         .rst_n_i  (ctrl_reset_n),
         .key_raw_i(w_raw[gi]),
         .key_o    (w_deb[gi])
      );
   end

   assign w_start_press = w_deb[c_KEY_START] & ~start_prev_q;

   // Register $4 is signed; negative or oversize values must never reach the VGA.
   always_comb begin
      if ($signed(spaceship_x_in) < X_MIN) begin
         w_x_clamped = X_W'(X_MIN);
      end else if ($signed(spaceship_x_in) > X_MAX) begin
         w_x_clamped = X_W'(X_MAX);
      end else begin
         w_x_clamped = spaceship_x_in[X_W-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (!ctrl_reset_n) begin
         state_q       <= RESET_REQ;
         fcnt_q        <= '0;
         start_prev_q  <= 1'b0;
         game_status_q <= 1'b1;
         move_left_q   <= 1'b0;
         move_right_q  <= 1'b0;
         x_q           <= X_W'(X_RESET);
      end else begin
         start_prev_q <= w_deb[c_KEY_START];
         move_left_q  <= w_deb[c_KEY_LEFT] & ~w_deb[c_KEY_RIGHT] & (state_q == PLAY);
         move_right_q <= w_deb[c_KEY_RIGHT] & ~w_deb[c_KEY_LEFT] & (state_q == PLAY);
         if (frame_tick) begin
            x_q <= w_x_clamped;
         end
         case (state_q)
            RESET_REQ: begin
               if (frame_tick) begin
                  if (fcnt_q == c_FCNT_LAST) begin
                     state_q       <= WAIT_START;
                     game_status_q <= 1'b0;
                     fcnt_q        <= '0;
                  end else begin
                     fcnt_q <= fcnt_q + 1'b1;
                  end
               end
            end
            WAIT_START: begin
               if (w_start_press) begin
                  state_q <= PLAY;
               end
            end
            PLAY: begin
               if (collision) begin
                  state_q <= OVER;
               end
            end
            OVER: begin
               if (w_start_press) begin
                  state_q       <= RESET_REQ;
                  game_status_q <= 1'b1;
                  fcnt_q        <= '0;
               end
            end
            default: begin
               state_q       <= RESET_REQ;
               game_status_q <= 1'b1;
               fcnt_q        <= '0;
            end
         endcase
      end
   end

   assign move_left       = move_left_q;
   assign move_right      = move_right_q;
   assign game_status     = game_status_q;
   assign spaceship_x_out = x_q;
   assign phase           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_game_io_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_game_io_ctrl                                            |
// | Brief   : Directed and randomised self-checking bench for game I/O.  |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_game_io_ctrl;

   localparam int c_DC  = 4;
   localparam int c_RHF = 2;

   logic        clock = 1'b0;
   logic        ctrl_reset_n;
   logic        key_left_raw;
   logic        key_right_raw;
   logic        key_start_raw;
   logic        collision;
   logic        frame_tick;
   logic [31:0] spaceship_x_in;
   logic        move_left;
   logic        move_right;
   logic        game_status;
   logic [9:0]  spaceship_x_out;
   logic [1:0]  phase;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   game_io_ctrl #(
      .DEBOUNCE_CYCLES  (c_DC),
      .RESET_HOLD_FRAMES(c_RHF),
      .X_W              (10),
      .X_MIN            (0),
      .X_MAX            (608),
      .X_RESET          (304)
   ) dut (
      .clock          (clock),
      .ctrl_reset_n   (ctrl_reset_n),
      .key_left_raw   (key_left_raw),
      .key_right_raw  (key_right_raw),
      .key_start_raw  (key_start_raw),
      .collision      (collision),
      .frame_tick     (frame_tick),
      .spaceship_x_in (spaceship_x_in),
      .move_left      (move_left),
      .move_right     (move_right),
      .game_status    (game_status),
      .spaceship_x_out(spaceship_x_out),
      .phase          (phase)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Reference model: keys are accepted once the last DC synchronised samples all disagree.
   bit m_s1 [3];
   bit m_s2 [3];
   bit m_lvl [3];
   bit m_win [3][c_DC];
   int m_nsamp [3];
   bit m_prev;
   int m_state;
   int m_fcnt;
   bit m_ml, m_mr, m_gs;
   int m_x;
   bit m_raw [3];
   bit m_press;
   bit m_alldiff;

   function automatic int clamp_x(input logic [31:0] v);
      int s;
      s = v;
      if (s < 0)   return 0;
      if (s > 608) return 608;
      return s;
   endfunction

   always @(posedge clock) begin
      m_raw[0] = key_left_raw;
      m_raw[1] = key_right_raw;
      m_raw[2] = key_start_raw;
      if (!ctrl_reset_n) begin
         for (int k = 0; k < 3; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_nsamp[k] = 0;
         end
         m_prev = 0; m_state = 0; m_fcnt = 0;
         m_ml = 0; m_mr = 0; m_gs = 1; m_x = 304;
      end else begin
         m_press = m_lvl[2] && !m_prev;
         m_prev  = m_lvl[2];
         m_ml = m_lvl[0] && !m_lvl[1] && (m_state == 2);
         m_mr = m_lvl[1] && !m_lvl[0] && (m_state == 2);
         if (frame_tick) m_x = clamp_x(spaceship_x_in);
         case (m_state)
            0: if (frame_tick) begin
                  m_fcnt++;
                  if (m_fcnt == c_RHF) begin m_state = 1; m_fcnt = 0; end
               end
            1: if (m_press) m_state = 2;
            2: if (collision) m_state = 3;
            default: if (m_press) begin m_state = 0; m_fcnt = 0; end
         endcase
         m_gs = (m_state == 0);
         for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < c_DC - 1; j++) m_win[k][j] = m_win[k][j+1];
            m_win[k][c_DC-1] = m_s2[k];
            m_nsamp[k]++;
            m_alldiff = (m_nsamp[k] >= c_DC);
            for (int j = 0; j < c_DC; j++)
               if (m_win[k][j] == m_lvl[k]) m_alldiff = 0;
            if (m_alldiff) m_lvl[k] = !m_lvl[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = m_raw[k];
         end
      end
   end

   always @(negedge clock) begin
      if (cmp_en) begin
         check("model move_left",   move_left,       m_ml);
         check("model move_right",  move_right,      m_mr);
         check("model game_status", game_status,     m_gs);
         check("model phase",       phase,           m_state);
         check("model x_out",       spaceship_x_out, m_x);
      end
   end

   initial begin
      logic [31:0] v;
      ctrl_reset_n   = 1'b0;
      key_left_raw   = 1'b0;
      key_right_raw  = 1'b0;
      key_start_raw  = 1'b0;
      collision      = 1'b0;
      frame_tick     = 1'b0;
      spaceship_x_in = 32'd304;
      @(posedge clock);
      #1 cmp_en = 1'b1;
      @(negedge clock);
      check("reset game_status", game_status, 1);
      check("reset phase", phase, 0);
      check("reset x_out", spaceship_x_out, 304);
      check("reset move_left", move_left, 0);
      ctrl_reset_n = 1'b1;
      cyc(3);

      // Two frame ticks release RESET_REQ
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      cyc(2);
      check("hold after 1st tick", game_status, 1);
      frame_tick = 1'b1;
      check("status before 2nd tick", game_status, 1);
      cyc(1); frame_tick = 1'b0;
      check("status after 2nd tick", game_status, 0);
      check("phase wait_start", phase, 1);
      check("x held at reset value", spaceship_x_out, 304);

      key_start_raw = 1'b1;
      cyc(6); check("phase before start press", phase, 1);
      cyc(1); check("phase play", phase, 2);
      cyc(3); key_start_raw = 1'b0;
      cyc(8);

      key_left_raw = 1'b1;
      cyc(6); check("move_left at 6 cycles", move_left, 0);
      cyc(1); check("move_left at 7 cycles", move_left, 1);

      key_right_raw = 1'b1; cyc(3); key_right_raw = 1'b0;
      cyc(8);
      check("right glitch rejected", move_right, 0);
      check("left survives glitch", move_left, 1);

      key_right_raw = 1'b1; cyc(10);
      check("both held left", move_left, 0);
      check("both held right", move_right, 0);
      key_right_raw = 1'b0; cyc(10);
      check("right released left", move_left, 1);

      spaceship_x_in = 32'hFFFF_FFF6; frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      check("clamp negative", spaceship_x_in == 32'hFFFF_FFF6 ? spaceship_x_out : 10'h3FF, 0);
      spaceship_x_in = 32'd700; frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      check("clamp high", spaceship_x_out, 608);
      spaceship_x_in = 32'd123; frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      check("pass through", spaceship_x_out, 123);
      spaceship_x_in = 32'd500; cyc(3);
      check("hold between ticks", spaceship_x_out, 123);

      // Start press lands in the same cycle as a collision
      key_start_raw = 1'b1;
      cyc(6); collision = 1'b1;
      cyc(1); collision = 1'b0;
      check("collision wins", phase, 3);
      cyc(1);
      check("over move_left", move_left, 0);
      check("over move_right", move_right, 0);
      cyc(3); key_start_raw = 1'b0;
      cyc(8);
      key_start_raw = 1'b1; cyc(8);
      check("over->reset phase", phase, 0);
      check("over->reset status", game_status, 1);
      cyc(2); key_start_raw = 1'b0; cyc(8);

      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      check("second round wait_start", phase, 1);
      key_start_raw = 1'b1; cyc(10); key_start_raw = 1'b0;
      check("second round play", phase, 2);
      cyc(2);
      check("play move_left again", move_left, 1);
      ctrl_reset_n = 1'b0; cyc(1); ctrl_reset_n = 1'b1;
      check("midgame reset move_left", move_left, 0);
      check("midgame reset status", game_status, 1);
      check("midgame reset phase", phase, 0);
      check("midgame reset x_out", spaceship_x_out, 304);

      key_left_raw = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) key_left_raw  = ~key_left_raw;
         if ($urandom_range(0, 9) == 0) key_right_raw = ~key_right_raw;
         if ($urandom_range(0, 5) == 0) key_start_raw = ~key_start_raw;
         collision  = ($urandom_range(0, 39) == 0);
         frame_tick = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0: spaceship_x_in = $urandom;
            1: begin v = $urandom_range(0, 20); spaceship_x_in = v - 32'd10; end
            2: spaceship_x_in = 32'd600 + $urandom_range(0, 15);
            default: spaceship_x_in = $urandom_range(0, 700);
         endcase
         ctrl_reset_n = ($urandom_range(0, 299) != 0);
         cyc(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
